mmio_io_responder: RTL and testbench

//  Responder on the CPU data-memory bus for the memory-mapped I/O window.
//  - The CPU issues MREAD/MWRITE on mem_cmd/mem_addr/write_data; this block answers hits in its address set.
//  - Holds the LED register, synchronises the switches, and provides a free-running cycle counter and a one-shot countdown timer.
//  - Sits beside the RAM; the top level selects between RAM data and io_rdata using io_sel.

---
 rtl/mem_bus_pkg.sv | 27 ++
 rtl/mmio_io_responder_if.sv | 29 ++
 rtl/mmio_countdown_timer.sv | 70 +++++++
 rtl/mmio_io_responder.sv | 122 ++++++++++++
 tb/tb_mmio_io_responder.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU data-memory bus and its I/O window.
//   - mem_cmd encodings (MNONE / MREAD / MWRITE; 2'b11 is treated as MNONE by responders)
//   - bus widths and the I/O register addresses
//   - countdown timer state type
package mem_bus_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_e;

  localparam logic [ADDR_W-1:0] LED_ADDR = 9'h100;
  localparam logic [ADDR_W-1:0] SW_ADDR  = 9'h140;
  localparam logic [ADDR_W-1:0] CNT_ADDR = 9'h180;
  localparam logic [ADDR_W-1:0] TMR_ADDR = 9'h1C0;
  localparam logic [ADDR_W-1:0] TST_ADDR = 9'h1C1;

  typedef enum logic {
    TmrIdle = 1'b0,
    TmrRun  = 1'b1
  } tmr_state_e;

endpackage

// File: rtl/mmio_io_responder_if.sv
// Data-memory bus as seen by the I/O responder.
//   master : CPU side, drives mem_cmd / mem_addr / write_data, receives io_sel / io_rdata
//   slave  : responder side, the reverse
interface mmio_io_responder_if;
  import mem_bus_pkg::*;

  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] write_data;
  logic              io_sel;
  logic [DATA_W-1:0] io_rdata;

  modport master (
    output mem_cmd,
    output mem_addr,
    output write_data,
    input  io_sel,
    input  io_rdata
  );

  modport slave (
    input  mem_cmd,
    input  mem_addr,
    input  write_data,
    output io_sel,
    output io_rdata
  );

endinterface

// File: rtl/mmio_countdown_timer.sv
// One-shot countdown timer with a sticky expired flag.
//   clk, reset : clock, asynchronous active-high reset
//   load       : load count from load_val (nonzero starts, zero stops)
//   load_val   : value to load
//   status_rd  : status read this edge; clears expired unless an expiry happens on the same edge
//   count      : current count (0 when idle)
//   expired    : sticky expiry flag
module mmio_countdown_timer
  import mem_bus_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  logic              status_rd,
  output logic [DATA_W-1:0] count,
  output logic              expired
);

  tmr_state_e        state_q, state_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              expired_q, expired_d;
  logic              expire_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= TmrIdle;
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  // A load always wins over the decrement.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      TmrIdle: begin
        if (load) begin
          count_d = load_val;
          state_d = (load_val != '0) ? TmrRun : TmrIdle;
        end
      end
      TmrRun: begin
        if (load) begin
          count_d = load_val;
          state_d = (load_val != '0) ? TmrRun : TmrIdle;
        end else begin
          count_d = count_q - DATA_W'(1);
          if (count_q == DATA_W'(1)) state_d = TmrIdle;
        end
      end
      default: state_d = TmrIdle;
    endcase
  end

  // Expiry is the 1 -> 0 point of the run; it still counts if a reload lands on it,
  // and it beats a simultaneous status-read clear.
  always_comb begin
    expire_set = (state_q == TmrRun) && (count_q == DATA_W'(1));
    expired_d  = expire_set | (expired_q & ~status_rd);
    count      = count_q;
    expired    = expired_q;
  end

endmodule

// File: rtl/mmio_io_responder.sv
// Responder for the memory-mapped I/O window on the CPU data-memory bus.
// Holds the LED register, a 2-flop switch synchroniser, a free-running cycle counter and,
// when MMIO_TIMER_EN is defined, a one-shot countdown timer (TMR/TST registers, timer_irq).
// Read data is registered: a hit at edge N presents io_sel/io_rdata for the following cycle.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of the data-memory bus (mem_cmd/mem_addr/write_data in,
//                io_sel/io_rdata out)
//   sw_in      : raw asynchronous switches
//   led_out    : LED register
//   timer_irq  : timer expired flag (tied 0 without MMIO_TIMER_EN)
module mmio_io_responder
  import mem_bus_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  mmio_io_responder_if.slave    bus,
  input  logic [7:0]            sw_in,
  output logic [7:0]            led_out,
  output logic                  timer_irq
);

  logic [7:0]        led_q, led_d;
  logic [7:0]        sw_meta_q, sw_meta_d;
  logic [7:0]        sw_sync_q, sw_sync_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              io_sel_q, io_sel_d;
  logic [DATA_W-1:0] io_rdata_q, io_rdata_d;

  logic rd, wr;
  assign rd = (bus.mem_cmd == MREAD);
  assign wr = (bus.mem_cmd == MWRITE);

`ifdef MMIO_TIMER_EN
  logic              tmr_load;
  logic              tmr_status_rd;
  logic [DATA_W-1:0] tmr_count;
  logic              tmr_expired;

  assign tmr_load      = wr && (bus.mem_addr == TMR_ADDR);
  assign tmr_status_rd = rd && (bus.mem_addr == TST_ADDR);

  mmio_countdown_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (tmr_load),
    .load_val  (bus.write_data),
    .status_rd (tmr_status_rd),
    .count     (tmr_count),
    .expired   (tmr_expired)
  );

  assign timer_irq = tmr_expired;
`else
  // Only the LED byte of write_data is used in this build.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^bus.write_data[DATA_W-1:8];
  assign timer_irq       = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q      <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      cnt_q      <= '0;
      io_sel_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      led_q      <= led_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      cnt_q      <= cnt_d;
      io_sel_q   <= io_sel_d;
      io_rdata_q <= io_rdata_d;
    end
  end

  always_comb begin
    led_d     = (wr && (bus.mem_addr == LED_ADDR)) ? bus.write_data[7:0] : led_q;
    sw_meta_d = sw_in;
    sw_sync_d = sw_meta_q;
    cnt_d     = cnt_q + DATA_W'(1);
  end

  // Read decode; anything that is not a read hit returns io_sel=0 with zero data.
  always_comb begin
    io_sel_d   = 1'b0;
    io_rdata_d = '0;
    if (rd) begin
      case (bus.mem_addr)
        LED_ADDR: begin
          io_sel_d   = 1'b1;
          io_rdata_d = {{(DATA_W-8){1'b0}}, led_q};
        end
        SW_ADDR: begin
          io_sel_d   = 1'b1;
          io_rdata_d = {{(DATA_W-8){1'b0}}, sw_sync_q};
        end
        CNT_ADDR: begin
          io_sel_d   = 1'b1;
          io_rdata_d = cnt_q;
        end
`ifdef MMIO_TIMER_EN
        TMR_ADDR: begin
          io_sel_d   = 1'b1;
          io_rdata_d = tmr_count;
        end
        TST_ADDR: begin
          io_sel_d   = 1'b1;
          io_rdata_d = {{(DATA_W-1){1'b0}}, tmr_expired};
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.io_sel   = io_sel_q;
  assign bus.io_rdata = io_rdata_q;
  assign led_out      = led_q;

endmodule

// File: tb/tb_mmio_io_responder.sv
module tb_mmio_io_responder;
  import mem_bus_pkg::*;

`ifdef MMIO_TIMER_EN
  localparam bit TimerEn = 1'b1;
`else
  localparam bit TimerEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw_in;
  logic [7:0] led_out;
  logic       timer_irq;

  mmio_io_responder_if bus ();

  mmio_io_responder dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: registers as plain values, timer as "cycles remaining".
  logic [7:0]  m_led;
  logic [7:0]  m_sw_seen1;   // switch value sampled one edge ago
  logic [7:0]  m_sw_seen2;   // switch value sampled two edges ago (what a read returns)
  logic [15:0] m_cnt;        // edges since reset release, modulo 2^16
  int          m_rem;
  bit          m_exp;
  bit          e_sel;
  logic [15:0] e_rdata;

  task automatic model_reset();
    m_led = 8'h00; m_sw_seen1 = 8'h00; m_sw_seen2 = 8'h00;
    m_cnt = 16'h0000; m_rem = 0; m_exp = 1'b0;
    e_sel = 1'b0; e_rdata = 16'h0000;
  endtask

  task automatic model_edge(input logic [1:0] cmd, input logic [8:0] addr,
                            input logic [15:0] wd);
    bit rd, wr, expiring;
    rd = (cmd == 2'b01);
    wr = (cmd == 2'b10);
    e_sel = 1'b0;
    e_rdata = 16'h0000;
    if (rd) begin
      if (addr == 9'h100) begin e_sel = 1'b1; e_rdata = {8'h00, m_led}; end
      else if (addr == 9'h140) begin e_sel = 1'b1; e_rdata = {8'h00, m_sw_seen2}; end
      else if (addr == 9'h180) begin e_sel = 1'b1; e_rdata = m_cnt; end
      else if (TimerEn && addr == 9'h1C0) begin e_sel = 1'b1; e_rdata = 16'(m_rem); end
      else if (TimerEn && addr == 9'h1C1) begin e_sel = 1'b1; e_rdata = {15'h0, m_exp}; end
    end
    expiring = TimerEn && (m_rem == 1);
    if (wr && addr == 9'h100) m_led = wd[7:0];
    if (TimerEn && wr && addr == 9'h1C0) m_rem = int'(wd);
    else if (m_rem > 0) m_rem = m_rem - 1;
    if (expiring) m_exp = 1'b1;
    else if (TimerEn && rd && addr == 9'h1C1) m_exp = 1'b0;
    m_sw_seen2 = m_sw_seen1;
    m_sw_seen1 = sw_in;
    m_cnt = m_cnt + 16'd1;
  endtask

  // Drive one bus cycle, advance the model, and land 1 time unit after the edge.
  task automatic step(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd);
    bus.mem_cmd    = cmd;
    bus.mem_addr   = addr;
    bus.write_data = wd;
    model_edge(cmd, addr, wd);
    @(posedge clk);
    #1;
    bus.mem_cmd = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mem_cmd = 2'b00; bus.mem_addr = '0; bus.write_data = '0;
    sw_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.io_sel !== 1'b0) $display("FAIL reset_io_sel got=%b want=0", bus.io_sel); else n_pass++;
    n_checks++; if (bus.io_rdata !== 16'h0) $display("FAIL reset_io_rdata got=%h want=0000", bus.io_rdata); else n_pass++;
    n_checks++; if (led_out !== 8'h00) $display("FAIL reset_led got=%h want=00", led_out); else n_pass++;
    n_checks++; if (timer_irq !== 1'b0) $display("FAIL reset_irq got=%b want=0", timer_irq); else n_pass++;
    model_reset();
    reset = 1'b0;
    step(2'b01, 9'h180, 16'h0);
    n_checks++; if (bus.io_sel !== 1'b1 || bus.io_rdata !== e_rdata || bus.io_rdata > 16'd3)
      $display("FAIL reset_cnt_read got sel=%b data=%h want sel=1 data=%h", bus.io_sel, bus.io_rdata, e_rdata);
    else n_pass++;
  endtask

  task automatic test_led();
    step(2'b10, 9'h100, 16'h00A5);
    n_checks++; if (led_out !== 8'hA5) $display("FAIL led_write got=%h want=a5", led_out); else n_pass++;
    n_checks++; if (bus.io_sel !== 1'b0) $display("FAIL led_write_sel got=%b want=0", bus.io_sel); else n_pass++;
    step(2'b01, 9'h100, 16'h0);
    n_checks++; if (bus.io_sel !== 1'b1 || bus.io_rdata !== 16'h00A5)
      $display("FAIL led_read got sel=%b data=%h want sel=1 data=00a5", bus.io_sel, bus.io_rdata);
    else n_pass++;
    step(2'b00, 9'h100, 16'h0);
    n_checks++; if (bus.io_sel !== 1'b0 || bus.io_rdata !== 16'h0)
      $display("FAIL led_sel_drop got sel=%b data=%h want sel=0 data=0000", bus.io_sel, bus.io_rdata);
    else n_pass++;
  endtask

  task automatic test_sw();
    sw_in = 8'h3C;
    step(2'b00, 9'h0, 16'h0);
    step(2'b01, 9'h140, 16'h0);
    n_checks++; if (bus.io_rdata !== 16'h0000 || bus.io_sel !== 1'b1)
      $display("FAIL sw_one_edge got sel=%b data=%h want sel=1 data=0000", bus.io_sel, bus.io_rdata);
    else n_pass++;
    step(2'b01, 9'h140, 16'h0);
    n_checks++; if (bus.io_rdata !== 16'h003C)
      $display("FAIL sw_two_edges got=%h want=003c", bus.io_rdata);
    else n_pass++;
  endtask

  task automatic test_timer();
    step(2'b10, 9'h1C0, 16'd5);
    n_checks++; if (timer_irq !== 1'b0) $display("FAIL tmr_start_irq got=%b want=0", timer_irq); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step(2'b00, 9'h0, 16'h0);
      n_checks++; if (timer_irq !== (TimerEn && i == 4))
        $display("FAIL tmr_irq_edge%0d got=%b want=%b", i + 1, timer_irq, TimerEn && i == 4);
      else n_pass++;
    end
    step(2'b01, 9'h1C1, 16'h0);
    n_checks++; if (bus.io_sel !== TimerEn || bus.io_rdata !== {15'h0, TimerEn})
      $display("FAIL tst_read1 got sel=%b data=%h want sel=%b data=%h", bus.io_sel, bus.io_rdata,
               TimerEn, {15'h0, TimerEn});
    else n_pass++;
    n_checks++; if (timer_irq !== 1'b0) $display("FAIL tst_clear_irq got=%b want=0", timer_irq); else n_pass++;
    step(2'b01, 9'h1C1, 16'h0);
    n_checks++; if (bus.io_sel !== TimerEn || bus.io_rdata !== 16'h0)
      $display("FAIL tst_read2 got sel=%b data=%h want sel=%b data=0000", bus.io_sel, bus.io_rdata, TimerEn);
    else n_pass++;
  endtask

  task automatic test_timer_corners();
    // Expiry coincides with a status read.
    step(2'b10, 9'h1C0, 16'd3);
    step(2'b00, 9'h0, 16'h0);
    step(2'b00, 9'h0, 16'h0);
    step(2'b01, 9'h1C1, 16'h0);
    n_checks++; if (bus.io_rdata !== 16'h0 || timer_irq !== TimerEn)
      $display("FAIL tst_vs_expire got data=%h irq=%b want data=0000 irq=%b", bus.io_rdata, timer_irq, TimerEn);
    else n_pass++;
    step(2'b01, 9'h1C1, 16'h0);
    n_checks++; if (bus.io_rdata !== {15'h0, TimerEn} || timer_irq !== 1'b0)
      $display("FAIL tst_after_race got data=%h irq=%b want data=%h irq=0", bus.io_rdata, timer_irq,
               {15'h0, TimerEn});
    else n_pass++;
    // Stop mid-run with a zero write.
    step(2'b10, 9'h1C0, 16'd10);
    step(2'b00, 9'h0, 16'h0);
    step(2'b10, 9'h1C0, 16'd0);
    step(2'b01, 9'h1C0, 16'h0);
    n_checks++; if (bus.io_sel !== TimerEn || bus.io_rdata !== 16'h0)
      $display("FAIL tmr_stop_count got sel=%b data=%h want sel=%b data=0000", bus.io_sel, bus.io_rdata, TimerEn);
    else n_pass++;
    repeat (12) step(2'b00, 9'h0, 16'h0);
    n_checks++; if (timer_irq !== 1'b0) $display("FAIL tmr_stop_irq got=%b want=0", timer_irq); else n_pass++;
    // Reload landing on the expiry edge still flags expiry, and the new count wins.
    step(2'b10, 9'h1C0, 16'd2);
    step(2'b00, 9'h0, 16'h0);
    step(2'b10, 9'h1C0, 16'd7);
    n_checks++; if (timer_irq !== TimerEn) $display("FAIL reload_expire_irq got=%b want=%b", timer_irq, TimerEn);
    else n_pass++;
    step(2'b01, 9'h1C0, 16'h0);
    n_checks++; if (bus.io_rdata !== (TimerEn ? 16'd7 : 16'd0))
      $display("FAIL reload_count got=%h want=%h", bus.io_rdata, TimerEn ? 16'd7 : 16'd0);
    else n_pass++;
    step(2'b10, 9'h1C0, 16'd0);
    step(2'b01, 9'h1C1, 16'h0);
    n_checks++; if (timer_irq !== 1'b0) $display("FAIL reload_clear_irq got=%b want=0", timer_irq); else n_pass++;
  endtask

  task automatic test_unmapped();
    step(2'b01, 9'h0F0, 16'h0);
    n_checks++; if (bus.io_sel !== 1'b0 || bus.io_rdata !== 16'h0)
      $display("FAIL ram_read got sel=%b data=%h want sel=0 data=0000", bus.io_sel, bus.io_rdata);
    else n_pass++;
    step(2'b11, 9'h100, 16'h00FF);
    n_checks++; if (bus.io_sel !== 1'b0 || led_out !== 8'hA5)
      $display("FAIL cmd11 got sel=%b led=%h want sel=0 led=a5", bus.io_sel, led_out);
    else n_pass++;
    step(2'b10, 9'h140, 16'hFFFF);
    step(2'b10, 9'h180, 16'hFFFF);
    step(2'b10, 9'h1C1, 16'hFFFF);
    n_checks++; if (led_out !== 8'hA5 || bus.io_sel !== 1'b0 || timer_irq !== 1'b0)
      $display("FAIL ro_writes got led=%h sel=%b irq=%b want led=a5 sel=0 irq=0", led_out, bus.io_sel, timer_irq);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [8:0] addrs [3];
    addrs[0] = 9'h100; addrs[1] = 9'h180; addrs[2] = 9'h140;
    for (int i = 0; i < 3; i++) begin
      step(2'b01, addrs[i], 16'h0);
      n_checks++; if (bus.io_sel !== 1'b1 || bus.io_rdata !== e_rdata)
        $display("FAIL b2b_%0d got sel=%b data=%h want sel=1 data=%h", i, bus.io_sel, bus.io_rdata, e_rdata);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_read();
    step(2'b01, 9'h100, 16'h0);
    #1;
    n_checks++; if (bus.io_sel !== 1'b1) $display("FAIL midrst_pre got=%b want=1", bus.io_sel); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (bus.io_sel !== 1'b0 || bus.io_rdata !== 16'h0 || led_out !== 8'h00)
      $display("FAIL midrst_drop got sel=%b data=%h led=%h want 0/0000/00", bus.io_sel, bus.io_rdata, led_out);
    else n_pass++;
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [8:0]  map [5];
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wd;
    map[0] = 9'h100; map[1] = 9'h140; map[2] = 9'h180; map[3] = 9'h1C0; map[4] = 9'h1C1;
    for (int i = 0; i < 400; i++) begin
      cmd  = 2'($urandom_range(3));
      addr = ($urandom_range(5) == 0) ? 9'($urandom) : map[$urandom_range(4)];
      wd   = 16'($urandom);
      if (addr == 9'h1C0 && $urandom_range(3) != 0) wd = 16'($urandom_range(8));
      if ($urandom_range(3) == 0) sw_in = 8'($urandom);
      step(cmd, addr, wd);
      n_checks++; if (bus.io_sel !== e_sel)
        $display("FAIL rnd%0d_sel got=%b want=%b", i, bus.io_sel, e_sel); else n_pass++;
      n_checks++; if (bus.io_rdata !== e_rdata)
        $display("FAIL rnd%0d_rdata got=%h want=%h", i, bus.io_rdata, e_rdata); else n_pass++;
      n_checks++; if (led_out !== m_led)
        $display("FAIL rnd%0d_led got=%h want=%h", i, led_out, m_led); else n_pass++;
      n_checks++; if (timer_irq !== m_exp)
        $display("FAIL rnd%0d_irq got=%b want=%b", i, timer_irq, m_exp); else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_led();
    test_sw();
    test_timer();
    test_timer_corners();
    test_unmapped();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
